// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen_3x3
//  Description : Streaming 3x3 sliding-window generator. Takes a raster-order
//                pixel stream and presents the nine taps of every full 3x3
//                window (row-major) to the downstream 9-operand adder.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      pixel / tap width in bits
//    IMG_W      image width in pixels (>=3)
//    IMG_H      image height in pixels (>=3)
//  Ports
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    in_pixel   input pixel, raster order
//    in_valid   in_pixel valid
//    in_ready   block accepts in_pixel this cycle
//    win1..win9 window taps; win1 = (r-2,c-2), win5 = centre, win9 = (r,c)
//    out_valid  win1..win9 hold a valid window
//    out_ready  consumer takes the window this cycle
//    out_last   final window of the frame (only with LAST_FLAG_EN)
//  Build option
//    LAST_FLAG_EN  when defined, adds the out_last port and its logic
// ============================================================================
module window_gen_3x3 #(
    parameter int WIDTH = 16,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_pixel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] win1,
    output logic [WIDTH-1:0] win2,
    output logic [WIDTH-1:0] win3,
    output logic [WIDTH-1:0] win4,
    output logic [WIDTH-1:0] win5,
    output logic [WIDTH-1:0] win6,
    output logic [WIDTH-1:0] win7,
    output logic [WIDTH-1:0] win8,
    output logic [WIDTH-1:0] win9,
    output logic             out_valid,
    input  logic             out_ready
`ifdef LAST_FLAG_EN
    ,
    output logic             out_last
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    // position of the next pixel to be accepted
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;

    // r_lb2 holds row r-2, r_lb1 holds row r-1, both indexed by column
    logic [WIDTH-1:0] r_lb1 [IMG_W];
    logic [WIDTH-1:0] r_lb2 [IMG_W];

    // the two previous window columns (c-2 and c-1), index 0 = top row
    logic [WIDTH-1:0] r_colm2 [3];
    logic [WIDTH-1:0] r_colm1 [3];

    logic [WIDTH-1:0] r_win [9];
    logic             r_valid;

    logic             w_accept;
    logic             w_emit;
    logic             w_col_end;
    logic             w_row_end;
    logic [WIDTH-1:0] w_newcol [3];
    logic [WIDTH-1:0] w_win    [9];

    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));
    // windows only for pixels at row>=2, col>=2, so they never span a row
    // wrap and never use rows left over from a previous frame
    assign w_emit    = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));

    // column entering the window: two buffered rows above plus the new pixel
    always_comb begin
        w_newcol[0] = r_lb2[r_col];
        w_newcol[1] = r_lb1[r_col];
        w_newcol[2] = in_pixel;
        for (int r = 0; r < 3; r++) begin
            w_win[r*3 + 0] = r_colm2[r];
            w_win[r*3 + 1] = r_colm1[r];
            w_win[r*3 + 2] = w_newcol[r];
        end
    end

    // raster position counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // line buffers and column history carry no reset: their contents are
    // always rewritten before any emitted window depends on them
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= in_pixel;
            for (int r = 0; r < 3; r++) begin
                r_colm2[r] <= r_colm1[r];
                r_colm1[r] <= w_newcol[r];
            end
        end
    end

    // single-entry output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_emit) begin
            r_valid <= 1'b1;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= w_win[i];
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef LAST_FLAG_EN
    logic r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_emit) begin
            r_last <= w_row_end && w_col_end;
        end else if (out_ready) begin
            r_last <= 1'b0;
        end
    end

    assign out_last = r_last;
`endif

    assign out_valid = r_valid;
    assign win1 = r_win[0];
    assign win2 = r_win[1];
    assign win3 = r_win[2];
    assign win4 = r_win[3];
    assign win5 = r_win[4];
    assign win6 = r_win[5];
    assign win7 = r_win[6];
    assign win8 = r_win[7];
    assign win9 = r_win[8];

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_gen_3x3
//  Description : Self-checking bench for window_gen_3x3 on a 4x4 image whose
//                pixel values are the raster index (plus a per-frame offset).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_window_gen_3x3;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_pixel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] win1, win2, win3, win4, win5, win6, win7, win8, win9;
    logic             out_valid;
    logic             out_ready;
`ifdef LAST_FLAG_EN
    logic             out_last;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    window_gen_3x3 #(.WIDTH(WIDTH), .IMG_W(4), .IMG_H(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_pixel (in_pixel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .win1     (win1),
        .win2     (win2),
        .win3     (win3),
        .win4     (win4),
        .win5     (win5),
        .win6     (win6),
        .win7     (win7),
        .win8     (win8),
        .win9     (win9),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef LAST_FLAG_EN
        ,
        .out_last (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pix;
        logic        vld;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
        int          widx;
        logic        exp_last;
    } vec_t;

    vec_t tv [17];

    // Window k of a 4x4 frame: top-left pixel at (k/2, k%2)
    function automatic logic [143:0] exp_win(input int k, input int off);
        logic [143:0] r;
        int base;
        r = '0;
        base = (k / 2) * 4 + (k % 2);
        for (int j = 0; j < 9; j++) begin
            r = {r[127:0], 16'(base + (j / 3) * 4 + (j % 3) + off)};
        end
        return r;
    endfunction

    function automatic int widx_of(input int p);
        case (p)
            10: return 0;
            11: return 1;
            14: return 2;
            15: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ov, input int widx, input int off,
                             input logic lst);
        check({name, ".out_valid"}, {143'd0, out_valid}, {143'd0, ov});
        if (widx >= 0)
            check({name, ".taps"}, {win1, win2, win3, win4, win5, win6, win7, win8, win9},
                  exp_win(widx, off));
`ifdef LAST_FLAG_EN
        check({name, ".out_last"}, {143'd0, out_last}, {143'd0, lst});
`else
        if (lst === 1'bx) $display("unused");
`endif
    endtask

    // drive inputs for one cycle and advance to just after the edge
    task automatic step(input logic [15:0] pix, input logic vld, input logic ordy);
        in_pixel  = pix;
        in_valid  = vld;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        in_pixel = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;

        // ---------------- reset state ----------------
        check("reset.out_valid", {143'd0, out_valid}, 144'd0);
        check("reset.taps", {win1, win2, win3, win4, win5, win6, win7, win8, win9}, 144'd0);
        check("reset.in_ready", {143'd0, in_ready}, {143'd0, 1'b1});
`ifdef LAST_FLAG_EN
        check("reset.out_last", {143'd0, out_last}, 144'd0);
`endif
        do_reset();

        // ---------------- table-driven fill ----------------
        for (int k = 0; k < 16; k++) begin
            tv[k].pix = 16'(k);
            tv[k].vld = 1'b1;
            tv[k].ordy = 1'b1;
            tv[k].exp_ir = 1'b1;
            tv[k].widx = widx_of(k);
            tv[k].exp_ov = (tv[k].widx >= 0);
            tv[k].exp_last = (k == 15);
        end
        tv[16] = '{pix: 16'd0, vld: 1'b0, ordy: 1'b1, exp_ir: 1'b1, exp_ov: 1'b0, widx: -1,
                   exp_last: 1'b0};

        for (int i = 0; i < 17; i++) begin
            in_pixel = tv[i].pix;
            in_valid = tv[i].vld;
            out_ready = tv[i].ordy;
            #1;
            check($sformatf("fill[%0d].in_ready", i), {143'd0, in_ready}, {143'd0, tv[i].exp_ir});
            @(posedge clk);
            #1;
            check_out($sformatf("fill[%0d]", i), tv[i].exp_ov, tv[i].widx, 0, tv[i].exp_last);
        end

        // ---------------- backpressure ----------------
        do_reset();
        for (int k = 0; k <= 10; k++) step(16'(k), 1'b1, 1'b0);
        check_out("bp.first", 1'b1, 0, 0, 1'b0);
        for (int h = 0; h < 2; h++) begin
            in_pixel = 16'd11;
            in_valid = 1'b1;
            out_ready = 1'b0;
            #1;
            check($sformatf("bp.hold%0d.in_ready", h), {143'd0, in_ready}, 144'd0);
            @(posedge clk);
            #1;
            check_out($sformatf("bp.hold%0d", h), 1'b1, 0, 0, 1'b0);
        end
        for (int k = 11; k < 16; k++) begin
            step(16'(k), 1'b1, 1'b1);
            check_out($sformatf("bp.rel%0d", k), widx_of(k) >= 0, widx_of(k), 0, k == 15);
        end
        // final window held under backpressure, then cleared
        for (int h = 0; h < 2; h++) begin
            step(16'd0, 1'b0, 1'b0);
            check_out($sformatf("bp.lasthold%0d", h), 1'b1, 3, 0, 1'b1);
        end
        step(16'd0, 1'b0, 1'b1);
        check_out("bp.clear", 1'b0, -1, 0, 1'b0);

        // ---------------- sparse input ----------------
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step(16'(k), 1'b1, 1'b1);
            check_out($sformatf("sparse.acc%0d", k), widx_of(k) >= 0, widx_of(k), 0, k == 15);
            step(16'hBEEF, 1'b0, 1'b1);
            check_out($sformatf("sparse.idle%0d", k), 1'b0, -1, 0, 1'b0);
        end

        // ---------------- back-to-back frames ----------------
        do_reset();
        for (int k = 0; k < 32; k++) begin
            step(16'((k % 16) + (k / 16) * 100), 1'b1, 1'b1);
            check_out($sformatf("b2b[%0d]", k), widx_of(k % 16) >= 0, widx_of(k % 16),
                      (k / 16) * 100, (k % 16) == 15);
        end

        // ---------------- reset mid-frame ----------------
        do_reset();
        for (int k = 0; k <= 10; k++) step(16'(k), 1'b1, 1'b0);
        check_out("midrst.before", 1'b1, 0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.out_valid", {143'd0, out_valid}, 144'd0);
        check("midrst.taps", {win1, win2, win3, win4, win5, win6, win7, win8, win9}, 144'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(16'(k), 1'b1, 1'b1);
            check_out($sformatf("midrst.fresh%0d", k), widx_of(k) >= 0, widx_of(k), 0, k == 15);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
